// File: rtl/q5_glitch_filter.sv
// ============================================================================
// Module   : q5_glitch_filter
// Purpose  : Synchronises and debounces the q5 hazard output and counts each
//            pulse that it rejects as a glitch.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module q5_glitch_filter #(
  parameter int FILT_LEN = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             en,
  input  logic             clr,
  output logic             dout,
  output logic             glitch_pulse,
  output logic [CNT_W-1:0] glitch_cnt,
  output logic             cnt_sat,
  output logic             busy
);

  localparam int RUN_W = $clog2(FILT_LEN);

  localparam logic [RUN_W-1:0] c_RUN_ONE  = RUN_W'(1);
  localparam logic [RUN_W-1:0] c_RUN_LAST = RUN_W'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] c_CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_PEND = 1'b1;

  logic             r_s1;
  logic             r_s2;
  logic [0:0]       r_state;
  logic [RUN_W-1:0] r_run;
  logic             r_busy;
  logic             r_dout;
  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;

  logic [0:0]       w_state_nxt;
  logic [RUN_W-1:0] w_run_nxt;
  logic             w_mismatch;
  logic             w_accept;
  logic             w_glitch;
  logic             w_dout_nxt;

  // Two-flop synchroniser runs regardless of en/clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= din;
      r_s2 <= r_s1;
    end
  end

  assign w_mismatch = (r_s2 != r_dout);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_run   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
      r_busy  <= (w_state_nxt == c_PEND);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    case (r_state)
      c_IDLE: begin
        if (w_mismatch && en) begin
          w_state_nxt = c_PEND;
          w_run_nxt   = c_RUN_ONE;
        end
      end
      c_PEND: begin
        if (!en || !w_mismatch || (r_run == c_RUN_LAST)) begin
          w_state_nxt = c_IDLE;
          w_run_nxt   = '0;
        end else begin
          w_run_nxt   = r_run + c_RUN_ONE;
        end
      end
      default: begin
        w_state_nxt = c_IDLE;
        w_run_nxt   = '0;
      end
    endcase
  end

  // A run that survives FILT_LEN samples is accepted; one that ends early is a glitch.
  always_comb begin
    w_accept   = (r_state == c_PEND) && en && w_mismatch && (r_run == c_RUN_LAST);
    w_glitch   = (r_state == c_PEND) && en && !w_mismatch;
    w_dout_nxt = w_accept ? r_s2 : r_dout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_dout  <= w_dout_nxt;
      r_pulse <= w_glitch;
    end
  end

  // clr takes priority over a coincident glitch; the pulse itself is unaffected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (clr) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (w_glitch && !(&r_cnt)) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == c_CNT_LAST) begin
        r_sat <= 1'b1;
      end
    end
  end

  assign dout         = r_dout;
  assign glitch_pulse = r_pulse;
  assign glitch_cnt   = r_cnt;
  assign cnt_sat      = r_sat;
  assign busy         = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_q5_glitch_filter.sv
// ============================================================================
// Module   : tb_q5_glitch_filter
// Purpose  : Directed self-checking bench for q5_glitch_filter (CNT_W 8 and 2).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_q5_glitch_filter;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic       en;
  logic       clr;

  logic       dout_a, pulse_a, sat_a, busy_a;
  logic [7:0] cnt_a;
  logic       dout_b, pulse_b, sat_b, busy_b;
  logic [1:0] cnt_b;

  int n_checks;
  int n_fails;

  // window statistics gathered by run_cycles
  int pulses;
  int pulse_pos;
  int dout_hi;

  q5_glitch_filter #(.FILT_LEN(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en), .clr(clr),
    .dout(dout_a), .glitch_pulse(pulse_a), .glitch_cnt(cnt_a),
    .cnt_sat(sat_a), .busy(busy_a)
  );

  q5_glitch_filter #(.FILT_LEN(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en), .clr(clr),
    .dout(dout_b), .glitch_pulse(pulse_b), .glitch_cnt(cnt_b),
    .cnt_sat(sat_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n negedges, recording pulses (and position of the first) on dut_a.
  task automatic run_cycles(input int n);
    pulses    = 0;
    pulse_pos = 0;
    dout_hi   = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (pulse_a) begin
        pulses++;
        if (pulse_pos == 0) pulse_pos = i;
      end
      if (dout_a) dout_hi = 1;
    end
  endtask

  // din high for exactly p clock periods, then low, then observe for w cycles.
  task automatic pulse_din(input int p, input int w);
    din = 1'b1;
    run_cycles(p);
    din = 1'b0;
    begin
      int pp, pc, dh;
      pp = pulse_pos; pc = pulses; dh = dout_hi;
      run_cycles(w);
      pulses  = pulses + pc;
      dout_hi = dout_hi | dh;
      pulse_pos = (pp != 0) ? pp : ((pulse_pos != 0) ? pulse_pos + p : 0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n = 1'b0;
    din   = 1'b0;
    en    = 1'b1;
    clr   = 1'b0;
    #23;
    chk("reset_dout", dout_a, 0);
    chk("reset_busy", busy_a, 0);
    chk("reset_cnt",  cnt_a,  0);
    chk("reset_sat",  sat_a,  0);
    @(negedge clk);
    rst_n = 1'b1;
    run_cycles(2);

    // 1: clean step, dout rises at the 6th edge, busy for the 3 edges before it
    din = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk($sformatf("step_dout_%0d", i), dout_a, (i == 6) ? 1 : 0);
      chk($sformatf("step_busy_%0d", i), busy_a, (i >= 3 && i <= 5) ? 1 : 0);
      chk($sformatf("step_pulse_%0d", i), pulse_a, 0);
    end
    run_cycles(4);
    chk("step_no_pulse", pulses, 0);
    chk("step_cnt", cnt_a, 0);
    din = 1'b0;
    run_cycles(8);
    chk("fall_dout", dout_a, 0);
    chk("fall_cnt", cnt_a, 0);

    // 2: 2- and 3-period excursions are glitches, 4 periods is accepted
    pulse_din(2, 8);
    chk("g2_dout", dout_hi, 0);
    chk("g2_pulses", pulses, 1);
    chk("g2_pos", pulse_pos, 5);
    chk("g2_cnt", cnt_a, 1);
    pulse_din(3, 8);
    chk("g3_dout", dout_hi, 0);
    chk("g3_pulses", pulses, 1);
    chk("g3_pos", pulse_pos, 6);
    chk("g3_cnt", cnt_a, 2);
    pulse_din(4, 8);
    chk("g4_dout_rose", dout_hi, 1);
    chk("g4_pulses", pulses, 0);
    chk("g4_cnt", cnt_a, 2);
    run_cycles(8);
    chk("g4_dout_back", dout_a, 0);

    // 4: clr coincident with a glitch event (1-period glitch, event at edge k+3)
    din = 1'b1;
    @(negedge clk);
    din = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clrg_pulse", pulse_a, 1);
    chk("clrg_cnt", cnt_a, 0);
    run_cycles(4);
    chk("clrg_cnt_hold", cnt_a, 0);

    // 3: 2-bit counter saturates at 3, sticky sat, then clr
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("sat_pre_cnt", cnt_b, 0);
    for (int g = 1; g <= 5; g++) begin
      pulse_din(1, 6);
      chk($sformatf("sat_cnt_%0d", g), cnt_b, (g < 3) ? g : 3);
      chk($sformatf("sat_flag_%0d", g), sat_b, (g >= 3) ? 1 : 0);
    end
    chk("sat_wide_cnt", cnt_a, 5);
    chk("sat_wide_flag", sat_a, 0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("sat_clr_cnt", cnt_b, 0);
    chk("sat_clr_flag", sat_b, 0);

    // 5: async reset in PEND with run=2, then full latency again
    din = 1'b1;
    run_cycles(4);
    chk("rst_busy_before", busy_a, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy_async", busy_a, 0);
    chk("rst_cnt_async", cnt_a, 0);
    chk("rst_dout_async", dout_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i >= 5) chk($sformatf("rst_relat_%0d", i), dout_a, (i == 6) ? 1 : 0);
    end
    chk("rst_no_cnt", cnt_a, 0);
    din = 1'b0;
    run_cycles(8);
    chk("rst_dout_back", dout_a, 0);

    // 6: en=0 freezes, and sub-cycle pulses are invisible
    en = 1'b0;
    pulse_din(2, 8);
    chk("en_g_pulses", pulses, 0);
    chk("en_g_dout", dout_hi, 0);
    pulse_din(5, 8);
    chk("en_p_pulses", pulses, 0);
    chk("en_p_dout", dout_hi, 0);
    chk("en_cnt", cnt_a, 0);
    chk("en_busy", busy_a, 0);
    en = 1'b1;
    #1 din = 1'b1;
    #1 din = 1'b0;
    run_cycles(8);
    chk("ns_pulses", pulses, 0);
    chk("ns_dout", dout_hi, 0);
    chk("ns_cnt", cnt_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
